reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-read-port integer register file for the single-cycle core. It holds DEPTH registers of XLEN bits, with register 0 hardwired to zero. A per-register scoreboard tracks pending writebacks. A sequential sweep engine zeroes the array after reset and on request, so the storage array needs no reset. It sits between decode (read addresses, issue) and writeback (write port), and replaces the single-port-pair, synchronously-cleared register file.

## Interface
- XLEN, 32, data width of each register
- DEPTH, 32, number of registers; power of two, at least 4
- NREAD, 2, number of read ports
- AW, $clog2(DEPTH), address width (derived)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- raddr  in  NREAD*AW  read addresses; port p at bits [p*AW +: AW]
- rdata  out  NREAD*XLEN  read data; port p at bits [p*XLEN +: XLEN]
- rbusy  out  NREAD  scoreboard busy bit of each read address
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  XLEN  write data
- issue_valid  in  1  an instruction writing issue_rd has issued
- issue_rd  in  AW  destination of the issued instruction
- clear_req  in  1  request a full zeroing sweep
- ready  out  1  high when the array is valid and accepts writes and issues

## Operation
- FSM states: SWEEP and RUN. Reset forces SWEEP with sweep index = 1.
- SWEEP:
  - Each cycle, writes 0 to the register at the sweep index, then increments the index.
  - After writing index DEPTH-1, moves to RUN.
  - ready = 0. we, issue_valid and clear_req are ignored.
  - All rdata read as 0 and all rbusy read as 0.
- RUN:
  - ready = 1.
  - clear_req moves to SWEEP with index 1 and clears every busy bit.
  - If clear_req is asserted, we and issue_valid in the same cycle are ignored.
- Reads are combinational: rdata[p] = registers[raddr[p]]. Address 0 always returns 0.
- Write: when ready && we && waddr != 0, registers[waddr] <= wdata. A write to address 0 is dropped.
- Scoreboard, one busy bit per register (bit 0 is constant 0):
  - ready && we clears busy[waddr].
  - ready && issue_valid && issue_rd != 0 sets busy[issue_rd].
  - If set and clear target the same register in the same cycle, set wins (the newer producer is pending).
- rbusy[p] = busy[raddr[p]]. It reflects registered state only; it is not bypassed.

## Timing
- Reset values: ready = 0, rbusy = 0, rdata = 0, all busy bits = 0, FSM = SWEEP, sweep index = 1.
- Initial sweep:
  - Begins on the first clock edge after rst deasserts.
  - Takes DEPTH-1 cycles.
  - ready rises on the edge that writes index DEPTH-1. The first accepted write is on the next edge.
- clear_req sweep:
  - clear_req seen high in RUN at edge N drops ready after edge N.
  - ready is high again after edge N+DEPTH-1.
- rst asserted mid-sweep or mid-RUN: the FSM and busy bits reset immediately, and the sweep restarts from index 1.
- A write is visible on rdata in the cycle after the write edge (no bypass).
- Busy set at edge N is visible on rbusy in cycle N+1. Busy clear behaves the same way.

## Configuration
- REG_FILE_BYPASS_EN defined:
  - Write-to-read forwarding on every port.
  - When ready && we && waddr != 0 && waddr == raddr[p], rdata[p] = wdata in the same cycle.
- Undefined: no forwarding. rdata shows the old value until the cycle after the write.
- rbusy is unaffected by the macro either way.

## Structure
- Package reg_file_pkg holds:
  - Defaults XLEN_DEF = 32, DEPTH_DEF = 32, NREAD_DEF = 2.
  - FSM state typedef: SWEEP, RUN.
  - Constant ZERO_REG = 0.
- Sub-module reg_file_scoreboard holds the busy vector with its set/clear/clear-all logic and the NREAD busy lookups.
- The array, the sweep FSM and the read muxes stay in reg_file_mp.

## Test plan
- Reset release, then poll ready
  -> ready = 0 for 31 cycles (DEPTH = 32), then 1.
  -> Reading every address gives 0.
- RUN: write 0xDEADBEEF to address 5 and 0x12345678 to address 0
  -> Next cycle, raddr[0] = 5 gives 0xDEADBEEF and raddr[1] = 0 gives 0.
- issue_valid with issue_rd = 7
  -> rbusy = 1 for address 7 next cycle.
- we at address 7 together with issue_valid at address 7
  -> Busy stays 1.
  -> A write alone afterwards clears it the following cycle.
- clear_req after filling registers 1..31 with nonzero data and setting busy bits
  -> ready = 0 for 31 cycles, and we pulses during that time are dropped.
  -> Afterwards all registers read 0 and all busy bits are 0.
- With REG_FILE_BYPASS_EN: write 0xA5A5A5A5 to address 3 while raddr[1] = 3
  -> rdata[1] = 0xA5A5A5A5 in the same cycle.
- Without REG_FILE_BYPASS_EN, the same stimulus
  -> rdata[1] shows the old value in that cycle.
- rst asserted mid-sweep at index 10
  -> Sweep restarts from index 1, and ready rises 31 cycles after release.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared defaults, FSM state type and constants for the multi-port register file.
package reg_file_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int DEPTH_DEF = 32;
   localparam int NREAD_DEF = 2;
   localparam int ZERO_REG  = 0;

   typedef enum logic [0:0] {
      SWEEP = 1'b0,
      RUN   = 1'b1
   } state_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-writeback busy bits, one per register; bit 0 is tied low.
module reg_file_scoreboard
   import reg_file_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int NREAD = NREAD_DEF,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_all,
   input  logic              set_en,
   input  logic [AW-1:0]     set_idx,
   input  logic              clr_en,
   input  logic [AW-1:0]     clr_idx,
   input  logic [NREAD*AW-1:0] raddr,
   output logic [NREAD-1:0]  rbusy
);

   logic [DEPTH-1:1] busy_hi;
   logic [DEPTH-1:0] busy;

   assign busy = {busy_hi, 1'b0};

   // Set beats clear so a newly issued producer stays pending over an older writeback.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_hi <= {(DEPTH-1){1'b0}};
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (clear_all) begin
               busy_hi[i] <= 1'b0;
            end else if (set_en && (set_idx == AW'(i))) begin
               busy_hi[i] <= 1'b1;
            end else if (clr_en && (clr_idx == AW'(i))) begin
               busy_hi[i] <= 1'b0;
            end else begin
               busy_hi[i] <= busy_hi[i];
            end
         end
      end
   end

   for (genvar p = 0; p < NREAD; p++) begin : g_lookup
      assign rbusy[p] = busy[raddr[p*AW +: AW]];
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with zeroing sweep and busy scoreboard.
// Optional write-to-read forwarding is enabled with REG_FILE_BYPASS_EN.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int NREAD = NREAD_DEF,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREAD*AW-1:0]   raddr,
   output logic [NREAD*XLEN-1:0] rdata,
   output logic [NREAD-1:0]      rbusy,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [XLEN-1:0]       wdata,
   input  logic                  issue_valid,
   input  logic [AW-1:0]         issue_rd,
   input  logic                  clear_req,
   output logic                  ready
);

   state_t          state;
   logic [AW-1:0]   sweep_idx;
   logic [XLEN-1:0] regs [DEPTH];
   logic            accept;
   logic            wr_en;
   logic            set_en;

   assign ready  = (state == RUN);
   assign accept = ready && !clear_req;
   assign wr_en  = accept && we && (waddr != AW'(ZERO_REG));
   assign set_en = accept && issue_valid && (issue_rd != AW'(ZERO_REG));

   // Sweep walks indices 1..DEPTH-1 then hands over to RUN.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= SWEEP;
         sweep_idx <= AW'(1);
      end else begin
         case (state)
            SWEEP: begin
               sweep_idx <= sweep_idx + AW'(1);
               if (sweep_idx == AW'(DEPTH-1)) begin
                  state <= RUN;
               end else begin
                  state <= SWEEP;
               end
            end
            RUN: begin
               if (clear_req) begin
                  state     <= SWEEP;
                  sweep_idx <= AW'(1);
               end else begin
                  state     <= RUN;
                  sweep_idx <= sweep_idx;
               end
            end
            default: begin
               state     <= SWEEP;
               sweep_idx <= AW'(1);
            end
         endcase
      end
   end

   // Storage has no reset; the sweep provides the zero contents.
   always_ff @(posedge clk) begin
      if (state == SWEEP) begin
         regs[sweep_idx] <= {XLEN{1'b0}};
      end else if (wr_en) begin
         regs[waddr] <= wdata;
      end
   end

   for (genvar p = 0; p < NREAD; p++) begin : g_read
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rd;

      assign ra = raddr[p*AW +: AW];

      // Read mux; everything reads zero until the array has been swept.
      always_comb begin
         rd = {XLEN{1'b0}};
         if (ready && (ra != AW'(ZERO_REG))) begin
            rd = regs[ra];
         end else begin
            rd = {XLEN{1'b0}};
         end
`ifdef REG_FILE_BYPASS_EN
         if (ready && we && (waddr != AW'(ZERO_REG)) && (waddr == ra)) begin
            rd = wdata;
         end else begin
            rd = rd;
         end
`endif
      end

      assign rdata[p*XLEN +: XLEN] = rd;
   end

   reg_file_scoreboard #(
      .DEPTH (DEPTH),
      .NREAD (NREAD),
      .AW    (AW)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .clear_all (ready && clear_req),
      .set_en    (set_en),
      .set_idx   (issue_rd),
      .clr_en    (accept && we),
      .clr_idx   (waddr),
      .raddr     (raddr),
      .rbusy     (rbusy)
   );

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard-driven bench for reg_file_mp (DEPTH=32, NREAD=2, XLEN=32).
module tb_reg_file_mp;

   logic        clk;
   logic        rst;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic [1:0]  rbusy;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        clear_req;
   logic        ready;

   logic [31:0] exp_q [$];
   logic [31:0] e;
   logic [31:0] got;
   int          vectors;
   int          miss;
   int          cnt;

   reg_file_mp dut (
      .clk         (clk),
      .rst         (rst),
      .raddr       (raddr),
      .rdata       (rdata),
      .rbusy       (rbusy),
      .we          (we),
      .waddr       (waddr),
      .wdata       (wdata),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .clear_req   (clear_req),
      .ready       (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      we = 1'b1; waddr = a; wdata = d;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      exp_q.push_back(32'd0);
      e = exp_q.pop_front(); vectors++;
      if ({31'd0, ready} !== e) begin miss++; $display("FAIL reset_ready got %0d want %0d", ready, e); end
      exp_q.push_back(32'd0);
      e = exp_q.pop_front(); vectors++;
      if (rdata[31:0] !== e) begin miss++; $display("FAIL reset_rdata got %h want %h", rdata[31:0], e); end
      @(negedge clk);
      rst = 1'b1;
      exp_q.push_back(32'd31);
      cnt = 0;
      while (ready !== 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
      e = exp_q.pop_front(); vectors++;
      if (cnt !== int'(e)) begin miss++; $display("FAIL init_sweep_len got %0d want %0d", cnt, e); end
      for (int a = 0; a < 32; a++) begin
         raddr = {a[4:0], a[4:0]};
         exp_q.push_back(32'd0); exp_q.push_back(32'd0);
         #1;
         e = exp_q.pop_front(); vectors++;
         if (rdata[31:0] !== e) begin miss++; $display("FAIL init_zero p0 a=%0d got %h want %h", a, rdata[31:0], e); end
         e = exp_q.pop_front(); vectors++;
         if ({30'd0, rbusy} !== e) begin miss++; $display("FAIL init_busy a=%0d got %b want 0", a, rbusy); end
      end
   endtask

   task automatic test_write;
      wr(5'd5, 32'hDEADBEEF);
      wr(5'd0, 32'h12345678);
      raddr = {5'd0, 5'd5};
      exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); vectors++;
      if (rdata[31:0] !== e) begin miss++; $display("FAIL write_a5 got %h want %h", rdata[31:0], e); end
      e = exp_q.pop_front(); vectors++;
      if (rdata[63:32] !== e) begin miss++; $display("FAIL write_a0 got %h want %h", rdata[63:32], e); end
   endtask

   task automatic test_issue;
      @(negedge clk);
      raddr = {5'd0, 5'd7};
      issue_valid = 1'b1; issue_rd = 5'd7;
      exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); vectors++;
      if ({31'd0, rbusy[0]} !== e) begin miss++; $display("FAIL issue_no_bypass got %b want %0d", rbusy[0], e); end
      @(negedge clk);
      issue_valid = 1'b0;
      exp_q.push_back(32'd1);
      #1;
      e = exp_q.pop_front(); vectors++;
      if ({31'd0, rbusy[0]} !== e) begin miss++; $display("FAIL issue_busy got %b want %0d", rbusy[0], e); end
   endtask

   task automatic test_set_wins;
      @(negedge clk);
      we = 1'b1; waddr = 5'd7; wdata = 32'h0000_0077;
      issue_valid = 1'b1; issue_rd = 5'd7;
      @(negedge clk);
      we = 1'b0; issue_valid = 1'b0;
      exp_q.push_back(32'd1); exp_q.push_back(32'h0000_0077);
      #1;
      e = exp_q.pop_front(); vectors++;
      if ({31'd0, rbusy[0]} !== e) begin miss++; $display("FAIL set_wins busy got %b want %0d", rbusy[0], e); end
      e = exp_q.pop_front(); vectors++;
      if (rdata[31:0] !== e) begin miss++; $display("FAIL set_wins data got %h want %h", rdata[31:0], e); end
      @(negedge clk);
      wr(5'd7, 32'h0000_0088);
      exp_q.push_back(32'd0); exp_q.push_back(32'h0000_0088);
      #1;
      e = exp_q.pop_front(); vectors++;
      if ({31'd0, rbusy[0]} !== e) begin miss++; $display("FAIL wr_clears busy got %b want %0d", rbusy[0], e); end
      e = exp_q.pop_front(); vectors++;
      if (rdata[31:0] !== e) begin miss++; $display("FAIL wr_clears data got %h want %h", rdata[31:0], e); end
   endtask

   task automatic test_bypass;
      @(negedge clk);
      wr(5'd3, 32'h0BADF00D);
      raddr = {5'd3, 5'd0};
      we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5;
`ifdef REG_FILE_BYPASS_EN
      exp_q.push_back(32'hA5A5A5A5);
`else
      exp_q.push_back(32'h0BADF00D);
`endif
      #1;
      e = exp_q.pop_front(); vectors++;
      if (rdata[63:32] !== e) begin miss++; $display("FAIL bypass_same_cycle got %h want %h", rdata[63:32], e); end
      @(negedge clk);
      we = 1'b0;
      exp_q.push_back(32'hA5A5A5A5);
      #1;
      e = exp_q.pop_front(); vectors++;
      if (rdata[63:32] !== e) begin miss++; $display("FAIL bypass_next_cycle got %h want %h", rdata[63:32], e); end
   endtask

   task automatic test_clear;
      @(negedge clk);
      for (int a = 1; a < 32; a++) wr(a[4:0], 32'h1000_0000 | a);
      issue_valid = 1'b1; issue_rd = 5'd3;
      @(negedge clk);
      issue_rd = 5'd31;
      @(negedge clk);
      issue_valid = 1'b0;
      raddr = {5'd3, 5'd31};
      exp_q.push_back(32'h1000_001F); exp_q.push_back(32'd3);
      #1;
      e = exp_q.pop_front(); vectors++;
      if (rdata[31:0] !== e) begin miss++; $display("FAIL pre_clear data got %h want %h", rdata[31:0], e); end
      e = exp_q.pop_front(); vectors++;
      if ({30'd0, rbusy} !== e) begin miss++; $display("FAIL pre_clear busy got %b want %b", rbusy, e[1:0]); end
      @(negedge clk);
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      exp_q.push_back(32'd31);
      cnt = 0;
      while (ready !== 1'b1 && cnt < 100) begin
         exp_q.push_back(32'd0);
         #1;
         e = exp_q.pop_back(); vectors++;
         if (rdata[31:0] !== e) begin miss++; $display("FAIL sweep_reads_zero got %h want %h", rdata[31:0], e); end
         we = 1'b1; waddr = 5'((cnt % 31) + 1); wdata = 32'hFFFF_FFFF;
         cnt++;
         @(negedge clk);
      end
      we = 1'b0;
      e = exp_q.pop_front(); vectors++;
      if (cnt !== int'(e)) begin miss++; $display("FAIL clear_sweep_len got %0d want %0d", cnt, e); end
      for (int a = 0; a < 32; a++) begin
         raddr = {a[4:0], a[4:0]};
         exp_q.push_back(32'd0); exp_q.push_back(32'd0);
         #1;
         e = exp_q.pop_front(); vectors++;
         if (rdata[63:32] !== e) begin miss++; $display("FAIL post_clear a=%0d got %h want %h", a, rdata[63:32], e); end
         e = exp_q.pop_front(); vectors++;
         if ({30'd0, rbusy} !== e) begin miss++; $display("FAIL post_clear_busy a=%0d got %b want 0", a, rbusy); end
      end
   endtask

   task automatic test_reset_mid_sweep;
      @(negedge clk);
      wr(5'd20, 32'hCAFE_0014);
      wr(5'd2, 32'hCAFE_0002);
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b0;
      raddr = {5'd2, 5'd20};
      exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); vectors++;
      if ({31'd0, ready} !== e) begin miss++; $display("FAIL mid_rst_ready got %0d want %0d", ready, e); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      exp_q.push_back(32'd31);
      cnt = 0;
      while (ready !== 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
      e = exp_q.pop_front(); vectors++;
      if (cnt !== int'(e)) begin miss++; $display("FAIL mid_rst_sweep_len got %0d want %0d", cnt, e); end
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); vectors++;
      if (rdata[31:0] !== e) begin miss++; $display("FAIL mid_rst_a20 got %h want %h", rdata[31:0], e); end
      e = exp_q.pop_front(); vectors++;
      if (rdata[63:32] !== e) begin miss++; $display("FAIL mid_rst_a2 got %h want %h", rdata[63:32], e); end
   endtask

   initial begin
      vectors = 0; miss = 0;
      rst = 1'b0; raddr = 10'd0; we = 1'b0; waddr = 5'd0; wdata = 32'd0;
      issue_valid = 1'b0; issue_rd = 5'd0; clear_req = 1'b0;
      repeat (3) @(negedge clk);
      test_reset;
      test_write;
      test_issue;
      test_set_wins;
      test_bypass;
      test_clear;
      test_reset_mid_sweep;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
      $finish;
   end

endmodule
